rej_uniform_sampler: RTL

Streaming rejection sampler for Dilithium matrix expansion (ExpandA / RejNTTPoly). It accepts a byte stream from the SHAKE128 squeeze path and packs each 3-byte group into a 23-bit candidate. Candidates >= Q are rejected; accepted coefficients are emitted over a valid/ready interface until N coefficients have been produced. Its successor role is to replace the single-shot combinational 3-byte-to-coefficient converter with a sequential, buffered, handshaked, multi-byte-per-beat block.

---
 rtl/rej_uniform_sampler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rej_uniform_sampler.sv
// Streaming rejection sampler for Dilithium ExpandA: packs 3-byte groups into 23-bit candidates and
// emits those below Q. Define REJ_STATS_EN to add the saturating rej_count output.
module rej_uniform_sampler #(
    parameter int unsigned IN_BYTES = 8,
    parameter int unsigned Q        = 8380417,
    parameter int unsigned COEFF_W  = 23,
    parameter int unsigned N        = 256,
    parameter int unsigned IDX_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*IN_BYTES-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [COEFF_W-1:0]    out_coeff,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef REJ_STATS_EN
    output logic [15:0]           rej_count,
`endif
    output logic                  done
);

    localparam int unsigned CAP    = IN_BYTES + 2;
    localparam int unsigned FILL_W = $clog2(CAP + 1);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam logic [23:0] Q_EXT  = 24'(Q);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [7:0]           r_buf [CAP];
    logic [7:0]           w_buf_next [CAP];
    logic [FILL_W-1:0]    r_fill;
    logic [FILL_W-1:0]    w_fill_next;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_next;
    logic                 r_out_valid;
    logic                 w_out_valid_next;
    logic [COEFF_W-1:0]   r_out_coeff;
    logic [COEFF_W-1:0]   w_out_coeff_next;
    logic [IDX_W-1:0]     r_out_index;
    logic [IDX_W-1:0]     w_out_index_next;

    logic                 w_run;
    logic                 w_start_ok;
    logic                 w_more;
    logic                 w_load;
    logic                 w_extract;
    logic                 w_accept;
    logic                 w_last_hs;
    logic [22:0]          w_cand;

    assign w_run      = (r_state == StRun);
    assign w_start_ok = start && (r_state != StRun);
    assign w_more     = (r_count < CNT_W'(N));
    assign w_load     = in_valid && in_ready;
    assign w_extract  = w_run && (r_fill >= FILL_W'(3)) && w_more && (!r_out_valid || out_ready);
    // Bit 7 of the third byte never contributes to the candidate.
    assign w_cand     = {r_buf[2][6:0], r_buf[1], r_buf[0]};
    assign w_accept   = w_extract && ({1'b0, w_cand} < Q_EXT);
    assign w_last_hs  = r_out_valid && out_ready && (r_out_index == IDX_W'(N - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (w_last_hs) w_state_next = StDone;
            StDone:  if (start) w_state_next = StRun;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = w_run && (r_fill < FILL_W'(3)) && w_more;
        done      = (r_state == StDone);
        out_valid = r_out_valid;
        out_coeff = r_out_coeff;
        out_index = r_out_index;
    end

    // Datapath next-state: byte buffer, fill level, coefficient counter and output register
    always_comb begin
        w_buf_next       = r_buf;
        w_fill_next      = r_fill;
        w_count_next     = r_count;
        w_out_valid_next = r_out_valid;
        w_out_coeff_next = r_out_coeff;
        w_out_index_next = r_out_index;

        if (w_start_ok) begin
            w_fill_next      = '0;
            w_count_next     = '0;
            w_out_valid_next = 1'b0;
        end else if (w_run) begin
            if (w_last_hs) begin
                // Leftover bytes are dropped on the way into DONE.
                w_fill_next      = '0;
                w_out_valid_next = 1'b0;
            end else begin
                if (w_load) begin
                    for (int unsigned f = 0; f < 3; f++) begin
                        if (r_fill == FILL_W'(f)) begin
                            for (int unsigned k = 0; k < IN_BYTES; k++) begin
                                w_buf_next[k + f] = in_data[8*k +: 8];
                            end
                        end
                    end
                    w_fill_next = r_fill + FILL_W'(IN_BYTES);
                end
                if (w_extract) begin
                    for (int unsigned i = 0; i < CAP - 3; i++) begin
                        w_buf_next[i] = r_buf[i + 3];
                    end
                    for (int unsigned i = CAP - 3; i < CAP; i++) begin
                        w_buf_next[i] = 8'h00;
                    end
                    w_fill_next = r_fill - FILL_W'(3);
                end
                if (w_accept) begin
                    w_out_valid_next = 1'b1;
                    w_out_coeff_next = COEFF_W'(w_cand);
                    w_out_index_next = r_count[IDX_W-1:0];
                    w_count_next     = r_count + CNT_W'(1);
                end else if (out_ready) begin
                    w_out_valid_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_fill      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_coeff <= '0;
            r_out_index <= '0;
        end else begin
            r_buf       <= w_buf_next;
            r_fill      <= w_fill_next;
            r_count     <= w_count_next;
            r_out_valid <= w_out_valid_next;
            r_out_coeff <= w_out_coeff_next;
            r_out_index <= w_out_index_next;
        end
    end

`ifdef REJ_STATS_EN
    logic [15:0] r_rej_count;
    logic [15:0] w_rej_count_next;

    always_comb begin
        w_rej_count_next = r_rej_count;
        if (w_start_ok) begin
            w_rej_count_next = '0;
        end else if (w_extract && !w_accept && (r_rej_count != 16'hFFFF)) begin
            w_rej_count_next = r_rej_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rej_count <= '0;
        end else begin
            r_rej_count <= w_rej_count_next;
        end
    end

    assign rej_count = r_rej_count;
`endif

endmodule
